bus_fabric: RTL and testbench
=============================

// Module: bus_fabric
// PURPOSE
//  Parametrised, registered write-back interconnect between the CPU data port and NSLAVE memory-mapped
//  slaves (RAM, button interface, future peripherals). Decodes the master address against per-slave
//  inclusive windows and runs a req/ack transaction through an FSM. Supports wait-stated slaves,
//  a per-access timeout and an error response for unmapped addresses. Replaces the fixed 2-slave mux.
// PARAMETERS
//  NSLAVE   2                          number of slave ports (1..8)
//  AW       32                         address width
//  DW       32                         data width
//  BASE     {32'd411700, 32'd0}        packed NSLAVE*AW, inclusive lower bound per slave (slave0 = LSBs)
//  LIMIT    {32'd411700, 32'd411699}   packed NSLAVE*AW, inclusive upper bound per slave
//  TIMEOUT  15                         max ACCESS cycles before error, 1..255
// PORTS
//  clock    in   1          system clock
//  nreset   in   1          synchronous active-low reset
//  m_req    in   1          master request, sampled only in IDLE
//  m_write  in   1          1 = write, 0 = read
//  m_addr   in   AW         master byte address
//  m_wdata  in   DW         master write data
//  m_rdata  out  DW         read data, valid when m_ack & ~m_write-of-txn; held until next ack
//  m_ack    out  1          one-cycle completion pulse
//  m_err    out  1          one-cycle error pulse, coincident with m_ack
//  s_sel    out  NSLAVE     one-hot slave select, held for the whole ACCESS phase
//  s_write  out  1          latched write flag, shared by all slaves
//  s_addr   out  AW         latched address minus BASE[idx] (slave-local offset)
//  s_wdata  out  DW         latched write data, shared
//  s_rdata  in   NSLAVE*DW  per-slave read data, slave i at [i*DW +: DW]
//  s_ready  in   NSLAVE     per-slave completion; only the selected bit is observed
// BEHAVIOUR
//  Clocking: one clock; reset is synchronous and active-low (clock, nreset).
//  Reset: state=IDLE; m_ack, m_err, s_sel, s_write = 0; m_rdata, s_addr, s_wdata = 0; timeout cnt = 0.
//  Decode: hit[i] = BASE[i] <= m_addr <= LIMIT[i], unsigned. On overlap, the lowest index wins.
//  FSM:
//   IDLE   -> if m_req: latch m_write, m_wdata, idx, offset.
//             On hit: go to ACCESS. On no hit: go to ERR.
//   ACCESS -> s_sel[idx]=1. Timeout cnt counts ACCESS cycles, starting at 1.
//             If s_ready[idx]: capture s_rdata[idx] into m_rdata (reads only; writes leave m_rdata)
//             and go to DONE.
//             Else if cnt==TIMEOUT: go to ERR. s_ready wins if it arrives in the TIMEOUT cycle.
//   DONE   -> m_ack=1, s_sel=0, then IDLE.
//   ERR    -> m_ack=1, m_err=1, s_sel=0, then IDLE. m_rdata is set to 0 for reads.
//  Latency: minimum 3 cycles from m_req sampled to m_ack (IDLE, ACCESS with ready, DONE).
//           +1 cycle per slave wait state. Unmapped access acks in 2 cycles.
//  m_req high during ACCESS/DONE/ERR is ignored. A held m_req starts a new txn in the next IDLE cycle.
//  No back-to-back overlap: at most one outstanding transaction.
//  s_sel is registered (no glitches). Unselected slaves never see s_sel. Writes occur only on s_sel & s_write.
//  Reset mid-operation: txn is aborted, s_sel drops at that edge, no ack is issued.
//  Elaboration: NSLAVE out of range, TIMEOUT out of range, or BASE>LIMIT for any i -> $error.
// STRUCTURE
//  bus_pkg:
//   - typedef enum logic [1:0] {IDLE, ACCESS, DONE, ERR} bus_state_t
//   - RAM_BASE/RAM_LIMIT=0/411699, BTN_ADDR=411700 constants
//  Sub-module bus_decoder: combinational m_addr -> hit, idx, offset.
//  Registered FSM, timeout counter and data path stay in bus_fabric.
// TESTING
//  1. Read addr 100, slave0 ready at once, rdata=32'h1234 -> ack at cycle 3, m_rdata=1234,
//     s_addr=100, m_err=0.
//  2. Write 411700 data 5, slave1 ready after 2 waits -> s_sel=2'b10 for 3 cycles, s_addr=0,
//     s_wdata=5, s_write=1, ack at cycle 5.
//  3. Read 411701 (unmapped) -> s_sel never asserted, m_ack&m_err at cycle 2, m_rdata=0.
//  4. Slave0 never ready, TIMEOUT=15 -> s_sel high 15 cycles, then m_ack&m_err.
//     Repeat with ready in cycle 15 -> m_err=0.
//  5. nreset low during ACCESS -> next cycle s_sel=0, state IDLE, no m_ack pulse.
//  6. m_req held high across 3 reads to 0,4,8 -> three acks, each txn restarts from IDLE,
//     correct m_rdata per txn.

Source files
------------

// File: rtl/bus_pkg.sv
// bus_pkg: shared FSM state type and default memory map for the bus fabric
package bus_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE, ERR} bus_state_t;

    localparam logic [31:0] RAM_BASE  = 32'd0;
    localparam logic [31:0] RAM_LIMIT = 32'd411699;
    localparam logic [31:0] BTN_ADDR  = 32'd411700;

endpackage

// File: rtl/bus_decoder.sv
// bus_decoder: maps a master address onto the lowest-indexed matching slave window
module bus_decoder #(
    parameter int NSLAVE = 2,
    parameter int AW     = 32,
    parameter int IW     = 1,
    parameter logic [NSLAVE*AW-1:0] BASE  = '0,
    parameter logic [NSLAVE*AW-1:0] LIMIT = '0
) (
    input  logic [AW-1:0] m_addr,
    output logic          hit,
    output logic [IW-1:0] idx,
    output logic [AW-1:0] offset
);

    // Walk from the top index down so the lowest matching window is the one left standing
    always_comb begin
        hit    = 1'b0;
        idx    = '0;
        offset = '0;
        for (int i = NSLAVE - 1; i >= 0; i--) begin
            if ((m_addr - BASE[i*AW +: AW]) <= (LIMIT[i*AW +: AW] - BASE[i*AW +: AW])) begin
                hit    = 1'b1;
                idx    = IW'(i);
                offset = m_addr - BASE[i*AW +: AW];
            end
        end
    end

endmodule

// File: rtl/bus_fabric.sv
// bus_fabric: registered req/ack interconnect from the CPU data port to NSLAVE slaves
module bus_fabric
    import bus_pkg::*;
#(
    parameter int NSLAVE = 2,
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter logic [NSLAVE*AW-1:0] BASE  = {BTN_ADDR, RAM_BASE},
    parameter logic [NSLAVE*AW-1:0] LIMIT = {BTN_ADDR, RAM_LIMIT},
    parameter int TIMEOUT = 15
) (
    input  logic               clock,
    input  logic               nreset,
    input  logic               m_req,
    input  logic               m_write,
    input  logic [AW-1:0]      m_addr,
    input  logic [DW-1:0]      m_wdata,
    output logic [DW-1:0]      m_rdata,
    output logic               m_ack,
    output logic               m_err,
    output logic [NSLAVE-1:0]  s_sel,
    output logic               s_write,
    output logic [AW-1:0]      s_addr,
    output logic [DW-1:0]      s_wdata,
    input  logic [NSLAVE*DW-1:0] s_rdata,
    input  logic [NSLAVE-1:0]  s_ready
);

    localparam int IW = NSLAVE > 1 ? $clog2(NSLAVE) : 1;

    if (NSLAVE < 1 || NSLAVE > 8) begin : g_nslave_chk
        $error("bus_fabric: NSLAVE must be 1..8");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_chk
        $error("bus_fabric: TIMEOUT must be 1..255");
    end
    for (genvar i = 0; i < NSLAVE; i++) begin : g_win_chk
        if (BASE[i*AW +: AW] > LIMIT[i*AW +: AW]) begin : g_bad
            $error("bus_fabric: BASE exceeds LIMIT for a slave window");
        end
    end

    logic              dec_hit;
    logic [IW-1:0]     dec_idx;
    logic [AW-1:0]     dec_off;

    bus_decoder #(
        .NSLAVE (NSLAVE),
        .AW     (AW),
        .IW     (IW),
        .BASE   (BASE),
        .LIMIT  (LIMIT)
    ) u_dec (
        .m_addr (m_addr),
        .hit    (dec_hit),
        .idx    (dec_idx),
        .offset (dec_off)
    );

    bus_state_t        state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [NSLAVE-1:0] s_sel_q, s_sel_d;
    logic              s_write_q, s_write_d;
    logic [AW-1:0]     s_addr_q, s_addr_d;
    logic [DW-1:0]     s_wdata_q, s_wdata_d;
    logic [DW-1:0]     m_rdata_q, m_rdata_d;
    logic              m_ack_q, m_ack_d;
    logic              m_err_q, m_err_d;

    // Next-state logic; ack/err/sel are computed one cycle early so every output comes straight from a flop
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        s_sel_d   = s_sel_q;
        s_write_d = s_write_q;
        s_addr_d  = s_addr_q;
        s_wdata_d = s_wdata_q;
        m_rdata_d = m_rdata_q;
        m_ack_d   = 1'b0;
        m_err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (m_req) begin
                    s_write_d = m_write;
                    s_wdata_d = m_wdata;
                    s_addr_d  = dec_off;
                    idx_d     = dec_idx;
                    if (dec_hit) begin
                        state_d = ACCESS;
                        s_sel_d = NSLAVE'(1) << dec_idx;
                        cnt_d   = 8'd1;
                    end else begin
                        state_d   = ERR;
                        m_ack_d   = 1'b1;
                        m_err_d   = 1'b1;
                        m_rdata_d = m_write ? m_rdata_q : '0;
                    end
                end
            end
            ACCESS: begin
                if (s_ready[idx_q]) begin
                    state_d   = DONE;
                    s_sel_d   = '0;
                    m_ack_d   = 1'b1;
                    m_rdata_d = s_write_q ? m_rdata_q : s_rdata[DW*int'(idx_q) +: DW];
                end else if (cnt_q == 8'(TIMEOUT)) begin
                    state_d   = ERR;
                    s_sel_d   = '0;
                    m_ack_d   = 1'b1;
                    m_err_d   = 1'b1;
                    m_rdata_d = s_write_q ? m_rdata_q : '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any transaction without an ack
    always_ff @(posedge clock) begin
        if (!nreset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            s_sel_q   <= '0;
            s_write_q <= 1'b0;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
            m_rdata_q <= '0;
            m_ack_q   <= 1'b0;
            m_err_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            s_sel_q   <= s_sel_d;
            s_write_q <= s_write_d;
            s_addr_q  <= s_addr_d;
            s_wdata_q <= s_wdata_d;
            m_rdata_q <= m_rdata_d;
            m_ack_q   <= m_ack_d;
            m_err_q   <= m_err_d;
        end
    end

    assign m_rdata = m_rdata_q;
    assign m_ack   = m_ack_q;
    assign m_err   = m_err_q;
    assign s_sel   = s_sel_q;
    assign s_write = s_write_q;
    assign s_addr  = s_addr_q;
    assign s_wdata = s_wdata_q;

endmodule

// File: tb/tb_bus_fabric.sv
// tb_bus_fabric: directed vectors for the bus fabric with hand-computed expectations
module tb_bus_fabric;

    logic        clock = 1'b0;
    logic        nreset = 1'b0;
    logic        m_req = 1'b0;
    logic        m_write = 1'b0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_wdata = '0;
    logic [31:0] m_rdata;
    logic        m_ack;
    logic        m_err;
    logic [1:0]  s_sel;
    logic        s_write;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [63:0] s_rdata;
    logic [1:0]  s_ready = '0;
    logic [31:0] rd0 = '0;
    logic [31:0] rd1 = '0;
    logic        model = 1'b0;
    int          checks = 0;
    int          errors = 0;
    int          n;

    assign s_rdata = {rd1, model ? s_addr + 32'h1000 : rd0};

    bus_fabric dut (
        .clock   (clock),
        .nreset  (nreset),
        .m_req   (m_req),
        .m_write (m_write),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_rdata (m_rdata),
        .m_ack   (m_ack),
        .m_err   (m_err),
        .s_sel   (s_sel),
        .s_write (s_write),
        .s_addr  (s_addr),
        .s_wdata (s_wdata),
        .s_rdata (s_rdata),
        .s_ready (s_ready)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(negedge clock);
    endtask

    // Present one request for a single sampling edge, then drop it
    task automatic start(input logic w, input logic [31:0] a, input logic [31:0] d);
        m_req   = 1'b1;
        m_write = w;
        m_addr  = a;
        m_wdata = d;
        tick;
        m_req   = 1'b0;
    endtask

    initial begin
        tick;
        tick;
        chk("rst_ack", m_ack, 0);
        chk("rst_err", m_err, 0);
        chk("rst_sel", s_sel, 0);
        chk("rst_write", s_write, 0);
        chk("rst_rdata", m_rdata, 0);
        chk("rst_saddr", s_addr, 0);
        chk("rst_wdata", s_wdata, 0);
        nreset = 1'b1;

        rd0 = 32'h1234;
        rd1 = 32'hdead;
        s_ready = 2'b01;
        start(1'b0, 32'd100, 32'd0);
        chk("t1_sel", s_sel, 2'b01);
        chk("t1_saddr", s_addr, 32'd100);
        chk("t1_early_ack", m_ack, 0);
        tick;
        chk("t1_ack", m_ack, 1);
        chk("t1_err", m_err, 0);
        chk("t1_rdata", m_rdata, 32'h1234);
        chk("t1_sel_clr", s_sel, 0);
        tick;
        chk("t1_pulse", m_ack, 0);
        chk("t1_hold", m_rdata, 32'h1234);

        s_ready = 2'b01;
        start(1'b1, 32'd411700, 32'd5);
        chk("t2_sel1", s_sel, 2'b10);
        chk("t2_saddr", s_addr, 0);
        chk("t2_swdata", s_wdata, 32'd5);
        chk("t2_swrite", s_write, 1);
        tick;
        chk("t2_sel2", s_sel, 2'b10);
        chk("t2_wait_ack", m_ack, 0);
        tick;
        chk("t2_sel3", s_sel, 2'b10);
        s_ready = 2'b10;
        tick;
        chk("t2_ack", m_ack, 1);
        chk("t2_err", m_err, 0);
        chk("t2_sel_clr", s_sel, 0);
        chk("t2_rdata_kept", m_rdata, 32'h1234);
        tick;
        s_ready = 2'b00;

        start(1'b0, 32'd200, 32'd0);
        n = 0;
        for (int i = 0; i < 40 && !m_ack; i++) begin
            if (s_sel == 2'b01) n++;
            tick;
        end
        chk("t4a_sel_cycles", n, 15);
        chk("t4a_ack", m_ack, 1);
        chk("t4a_err", m_err, 1);
        chk("t4a_rdata", m_rdata, 0);
        chk("t4a_sel_clr", s_sel, 0);
        tick;

        rd0 = 32'h55;
        start(1'b0, 32'd200, 32'd0);
        n = 0;
        for (int i = 0; i < 40 && !m_ack; i++) begin
            if (s_sel == 2'b01) n++;
            if (n == 15) s_ready = 2'b01;
            tick;
        end
        chk("t4b_sel_cycles", n, 15);
        chk("t4b_ack", m_ack, 1);
        chk("t4b_err", m_err, 0);
        chk("t4b_rdata", m_rdata, 32'h55);
        tick;
        s_ready = 2'b00;

        start(1'b0, 32'd411701, 32'd0);
        chk("t3_ack", m_ack, 1);
        chk("t3_err", m_err, 1);
        chk("t3_sel", s_sel, 0);
        chk("t3_rdata", m_rdata, 0);
        tick;
        chk("t3_pulse", m_ack, 0);
        chk("t3_err_pulse", m_err, 0);
        chk("t3_sel_after", s_sel, 0);

        rd0 = 32'h77;
        start(1'b0, 32'd100, 32'd0);
        chk("t5_sel", s_sel, 2'b01);
        nreset = 1'b0;
        tick;
        chk("t5_sel_drop", s_sel, 0);
        chk("t5_ack", m_ack, 0);
        chk("t5_saddr", s_addr, 0);
        nreset = 1'b1;
        s_ready = 2'b01;
        n = 0;
        repeat (5) begin
            tick;
            if (m_ack) n++;
        end
        chk("t5_no_ack", n, 0);
        chk("t5_rdata", m_rdata, 0);

        model = 1'b1;
        s_ready = 2'b01;
        m_req = 1'b1;
        m_write = 1'b0;
        for (int k = 0; k < 3; k++) begin
            m_addr = 32'(4 * k);
            tick;
            n = 0;
            while (!m_ack && n < 10) begin
                tick;
                n++;
            end
            chk("t6_latency", n, 1);
            chk("t6_rdata", m_rdata, 32'h1000 + 32'(4 * k));
            tick;
            chk("t6_pulse", m_ack, 0);
        end
        m_req = 1'b0;
        tick;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
